router_pkt_tx: RTL and testbench

//  Packet transmitter feeding the 1x3 router input port (pkt_valid/din/busy).

---
 rtl/router_pkt_tx.sv | 147 ++++++++++++++
 tb/tb_router_pkt_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input port: buffers a payload from an
// upstream byte stream, then emits header, payload and parity honouring busy.
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] din,
  output logic       idle,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [5:0] len_q;
  logic [1:0] dest_q;
  logic [5:0] wptr;
  logic [5:0] rptr;
  logic [7:0] parity;
  logic [3:0] gap_cnt;
  logic [5:0] last_idx;
  logic       load_take;

  logic [7:0] pl_buf [0:MAX_LEN-1];

  function automatic logic [7:0] header_byte(input logic [5:0] l, input logic [1:0] d);
    return {l, d};
  endfunction

  assign last_idx  = len_q - 6'd1;
  assign load_take = (state == S_LOAD) && pl_valid;

  // Payload storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (load_take) begin
      pl_buf[wptr] <= pl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pkt_valid <= 1'b0;
      din       <= 8'h00;
      pl_ready  <= 1'b0;
      idle      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      wptr      <= 6'd0;
      rptr      <= 6'd0;
      parity    <= 8'h00;
      gap_cnt   <= 4'd0;
      len_q     <= 6'd0;
      dest_q    <= 2'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q  <= len;
            dest_q <= dest;
            if (len == 6'd0 || dest == 2'b11) begin
              err <= 1'b1;
            end else begin
              state    <= S_LOAD;
              pl_ready <= 1'b1;
              idle     <= 1'b0;
              parity   <= header_byte(len, dest);
              wptr     <= 6'd0;
            end
          end
        end
        S_LOAD: begin
          if (pl_valid) begin
            wptr   <= wptr + 6'd1;
            parity <= parity ^ pl_data;
            if (wptr == last_idx) begin
              state     <= S_HEADER;
              pl_ready  <= 1'b0;
              pkt_valid <= 1'b1;
              din       <= header_byte(len_q, dest_q);
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            state <= S_PAYLOAD;
            rptr  <= 6'd0;
            din   <= pl_buf[0];
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (rptr == last_idx) begin
              state     <= S_PARITY;
              pkt_valid <= 1'b0;
              din       <= parity;
            end else begin
              rptr <= rptr + 6'd1;
              din  <= pl_buf[rptr + 6'd1];
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            state   <= S_GAP;
            din     <= 8'h00;
            gap_cnt <= 4'd0;
          end
        end
        S_GAP: begin
          // Inter-packet gap runs regardless of busy.
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            idle  <= 1'b1;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Table-driven bench for router_pkt_tx: packets are described by records with
// hand-computed header/parity; reject and reset cases are hand-written sequences.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] len = 6'd0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] din;
  logic       idle;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dest(dest), .len(len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .busy(busy),
    .pkt_valid(pkt_valid), .din(din), .idle(idle), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] dest;
    logic [5:0] len;
    bit         seq;
    bit         toggle;
    int         busy_beat;
    int         busy_cyc;
    int         abort_beat;
    bit         spulse;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input string nm, input logic [1:0] d, input logic [5:0] l,
                              input bit sq, input bit tg, input int bb, input int bc,
                              input int ab, input bit sp, input logic [7:0] h,
                              input logic [7:0] p);
    vec_t v;
    v.name = nm; v.dest = d; v.len = l; v.seq = sq; v.toggle = tg;
    v.busy_beat = bb; v.busy_cyc = bc; v.abort_beat = ab; v.spulse = sp;
    v.exp_hdr = h; v.exp_par = p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_pkt(input vec_t v);
    logic [7:0] pay [0:62];
    logic [7:0] par;
    logic [7:0] dexp;
    logic       pvexp;
    int l, k, nc, b, bleft, guard;
    l   = int'(v.len);
    par = {v.len, v.dest};
    for (int i = 0; i < l; i++) begin
      pay[i] = v.seq ? 8'(i + 1) : 8'($urandom);
      par ^= pay[i];
    end
    if (v.seq) par = v.exp_par;

    start = 1'b1; dest = v.dest; len = v.len;
    @(negedge clk);
    start = 1'b0;
    nc = 1;
    chk({v.name, " accept"}, 32'({idle, err, done, pl_ready}), 32'(4'b0001));

    k = 0; guard = 0;
    while (k < l && guard < 300) begin
      if (pl_ready) begin
        pl_valid = v.toggle ? ~guard[0] : 1'b1;
        pl_data  = pay[k];
        if (pl_valid) k++;
      end else begin
        pl_valid = 1'b0;
      end
      @(negedge clk);
      nc++; guard++;
    end
    pl_valid = 1'b0;
    if (guard >= 300) chk({v.name, " load_timeout"}, 32'(k), 32'(l));
    if (!v.toggle) chk({v.name, " hdr_time"}, 32'(nc), 32'(l + 1));

    b = 0; bleft = v.busy_cyc; guard = 0;
    while (b <= l + 1 && guard < 400) begin
      if (b == v.abort_beat) begin
        rst = 1'b1; busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk({v.name, " after_rst"}, 32'({pkt_valid, din, idle, pl_ready, done, err}),
            32'({1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}));
        return;
      end
      pvexp = (b <= l);
      dexp  = (b == 0) ? v.exp_hdr : ((b <= l) ? pay[b-1] : par);
      chk($sformatf("%s beat%0d", v.name, b), 32'({pkt_valid, din, idle, pl_ready}),
          32'({pvexp, dexp, 2'b00}));
      start    = v.spulse && (b == 2);
      dest     = 2'd0;
      len      = 6'd3;
      pl_valid = v.spulse;
      if (b == v.busy_beat && bleft > 0) begin
        busy = 1'b1; bleft--;
      end else begin
        busy = 1'b0; b++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0; pl_valid = 1'b0;
    if (guard >= 400) chk({v.name, " beat_timeout"}, 32'(b), 32'(l + 2));

    busy = 1'b1;
    chk({v.name, " gap1"}, 32'({pkt_valid, din, done, idle}), 32'(0));
    start = v.spulse;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, " gap2"}, 32'({pkt_valid, din, done, idle}), 32'(0));
    @(negedge clk);
    busy = 1'b0;
    chk({v.name, " done"}, 32'({done, idle, err, pkt_valid}), 32'(4'b1100));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk("T1",   2'd1, 6'd4,  1, 0, -1, 0, -1, 0, 8'h11, 8'h15);
    vecs[1] = mk("T2",   2'd0, 6'd16, 0, 0,  3, 3, -1, 0, 8'h40, 8'h00);
    vecs[2] = mk("T4",   2'd2, 6'd63, 1, 1, -1, 0, -1, 0, 8'hFE, 8'hFE);
    vecs[3] = mk("T5a",  2'd1, 6'd10, 1, 0, -1, 0,  6, 0, 8'h29, 8'h00);
    vecs[4] = mk("T5b",  2'd2, 6'd2,  1, 0, -1, 0, -1, 0, 8'h0A, 8'h09);
    vecs[5] = mk("T6",   2'd1, 6'd5,  1, 0, -1, 0, -1, 1, 8'h15, 8'h14);
    vecs[6] = mk("T6b",  2'd0, 6'd3,  0, 0, -1, 0, -1, 0, 8'h0C, 8'h00);
    vecs[7] = mk("PBSY", 2'd2, 6'd1,  1, 0,  2, 2, -1, 0, 8'h06, 8'h07);
    vecs[8] = mk("HBSY", 2'd0, 6'd2,  1, 0,  0, 1, -1, 0, 8'h08, 8'h0B);

    repeat (2) @(negedge clk);
    chk("reset", 32'({pkt_valid, din, pl_ready, idle, done, err}),
        32'({1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    @(negedge clk);

    // Rejected starts: zero length, then destination 3.
    start = 1'b1; dest = 2'd1; len = 6'd0;
    @(negedge clk);
    start = 1'b0;
    chk("err_len0", 32'({err, idle, pkt_valid, pl_ready}), 32'(4'b1100));
    @(negedge clk);
    chk("err_len0_clr", 32'({err, idle}), 32'(2'b01));
    start = 1'b1; dest = 2'd3; len = 6'd5;
    @(negedge clk);
    start = 1'b0;
    chk("err_dest3", 32'({err, idle, pkt_valid, pl_ready}), 32'(4'b1100));
    @(negedge clk);
    chk("err_dest3_clr", 32'({err, idle, pkt_valid}), 32'(3'b010));

    for (int i = 0; i < 9; i++) run_pkt(vecs[i]);

    @(negedge clk);
    chk("final_idle", 32'({idle, done, err, pkt_valid}), 32'(4'b1000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
